// File: rtl/mem2io_ctrl.sv
// SLC-3 memory/I-O controller: request/ready handshake toward the CPU, wait-stated
// async SRAM access, and a small memory-mapped register bank (switches, hex, LEDs, txn count).
module mem2io_ctrl #(
   parameter int                DATA_W      = 16,
   parameter int                CPU_ADDR_W  = 16,
   parameter int                ADDR_W      = 20,
   parameter int                HEX_DIGITS  = 4,
   parameter int                LED_W       = 12,
   parameter int                WAIT_STATES = 1,
   parameter logic [15:0]       IO_BASE     = 16'hFFF0
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [CPU_ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    cpu_ready,
   input  logic [DATA_W-1:0]       Switches,
   output logic [HEX_DIGITS*4-1:0] hex_out,
   output logic [LED_W-1:0]        led_out,
   output logic                    CE,
   output logic                    OE,
   output logic                    WE,
   output logic                    UB,
   output logic                    LB,
   output logic [ADDR_W-1:0]       ADDR,
   output logic [DATA_W-1:0]       Data_to_SRAM,
   input  logic [DATA_W-1:0]       Data_from_SRAM,
   output logic                    sram_drive
);

   localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [WCNT_W-1:0]     WCNT_INIT = WCNT_W'(WAIT_STATES);
   localparam logic [CPU_ADDR_W-1:0] IO_BASE_A = CPU_ADDR_W'(IO_BASE);
   localparam logic [CPU_ADDR_W-1:0] A_SW      = CPU_ADDR_W'(16'hFFFF);
   localparam logic [CPU_ADDR_W-1:0] A_LED     = CPU_ADDR_W'(16'hFFFE);
   localparam logic [CPU_ADDR_W-1:0] A_TXN     = CPU_ADDR_W'(16'hFFFD);

   typedef enum logic [1:0] {IDLE, MEM_ACC, MEM_END, IO_ACC} state_t;

   state_t                    state_q;
   logic [WCNT_W-1:0]         wcnt_q;
   logic                      we_q;
   logic [ADDR_W-1:0]         addr_q;
   logic [DATA_W-1:0]         wdata_q;
   logic [DATA_W-1:0]         rdata_q;
   logic                      ready_q;
   logic                      ce_q, oe_q, wen_q, drive_q;
   logic [HEX_DIGITS*4-1:0]   hex_q;
   logic [LED_W-1:0]          led_q;
   logic [DATA_W-1:0]         txn_q;
   logic [DATA_W-1:0]         sw_meta_q, sw_sync_q;
   logic [DATA_W-1:0]         io_rdata_d;
   logic [CPU_ADDR_W-1:0]     io_addr;

   assign io_addr = addr_q[CPU_ADDR_W-1:0];

   // I/O read data is decoded from the live request so it is ready the cycle after the request edge
   always_comb begin
      io_rdata_d = '0;
      if (cpu_addr == A_SW)
         io_rdata_d = sw_sync_q;
      else if (cpu_addr == A_LED)
         io_rdata_d = DATA_W'(led_q);
      else if (cpu_addr == A_TXN)
         io_rdata_d = txn_q;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= Switches;
         sw_sync_q <= sw_meta_q;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         ce_q    <= 1'b1;
         oe_q    <= 1'b1;
         wen_q   <= 1'b1;
         drive_q <= 1'b0;
         hex_q   <= '0;
         led_q   <= '0;
         txn_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu_req) begin
                  addr_q  <= ADDR_W'(cpu_addr);
                  we_q    <= cpu_we;
                  wdata_q <= cpu_wdata;
                  if (cpu_addr >= IO_BASE_A) begin
                     state_q <= IO_ACC;
                     ready_q <= 1'b1;
                     if (!cpu_we)
                        rdata_q <= io_rdata_d;
                  end else begin
                     state_q <= MEM_ACC;
                     wcnt_q  <= WCNT_INIT;
                     ce_q    <= 1'b0;
                     oe_q    <= cpu_we;
                     wen_q   <= !cpu_we;
                     drive_q <= cpu_we;
                  end
               end
            end
            MEM_ACC: begin
               if (wcnt_q == '0) begin
                  state_q <= MEM_END;
                  ce_q    <= 1'b1;
                  oe_q    <= 1'b1;
                  wen_q   <= 1'b1;
                  ready_q <= 1'b1;
                  if (!we_q)
                     rdata_q <= Data_from_SRAM;
               end else begin
                  wcnt_q <= wcnt_q - 1'b1;
               end
            end
            // Write data stays driven through MEM_END as the SRAM hold cycle
            MEM_END: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               drive_q <= 1'b0;
               txn_q   <= txn_q + 1'b1;
            end
            IO_ACC: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               if (we_q) begin
                  if (io_addr == A_SW)
                     hex_q <= wdata_q[HEX_DIGITS*4-1:0];
                  else if (io_addr == A_LED)
                     led_q <= wdata_q[LED_W-1:0];
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               ce_q    <= 1'b1;
               oe_q    <= 1'b1;
               wen_q   <= 1'b1;
               drive_q <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_rdata    = rdata_q;
   assign cpu_ready    = ready_q;
   assign hex_out      = hex_q;
   assign led_out      = led_q;
   assign CE           = ce_q;
   assign UB           = ce_q;
   assign LB           = ce_q;
   assign OE           = oe_q;
   assign WE           = wen_q;
   assign ADDR         = addr_q;
   assign Data_to_SRAM = wdata_q;
   assign sram_drive   = drive_q;

endmodule

// File: tb/tb_mem2io_ctrl.sv
// Directed bench for mem2io_ctrl: memory read/write timing, I/O register map, reset abort.
module tb_mem2io_ctrl;

   logic        Clk;
   logic        Reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic [15:0] Switches;
   logic [15:0] hex_out;
   logic [11:0] led_out;
   logic        CE, OE, WE, UB, LB;
   logic [19:0] ADDR;
   logic [15:0] Data_to_SRAM;
   logic [15:0] Data_from_SRAM;
   logic        sram_drive;

   int n_checks;
   int n_errors;

   mem2io_ctrl #(
      .DATA_W(16), .CPU_ADDR_W(16), .ADDR_W(20), .HEX_DIGITS(4),
      .LED_W(12), .WAIT_STATES(1), .IO_BASE(16'hFFF0)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .Switches(Switches), .hex_out(hex_out), .led_out(led_out),
      .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
      .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
      .sram_drive(sram_drive)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Presents a request for exactly one edge; returns in the first cycle after it
   task automatic req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      tick();
      cpu_req   = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      Reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      Switches = '0; Data_from_SRAM = '0;

      #3 Reset = 1'b0;
      #1;
      chk("rst_CE", CE, 1); chk("rst_OE", OE, 1); chk("rst_WE", WE, 1);
      chk("rst_UB", UB, 1); chk("rst_LB", LB, 1);
      chk("rst_drive", sram_drive, 0); chk("rst_ready", cpu_ready, 0);
      chk("rst_rdata", cpu_rdata, 0); chk("rst_hex", hex_out, 0); chk("rst_led", led_out, 0);
      chk("rst_ADDR", ADDR, 0); chk("rst_d2s", Data_to_SRAM, 0);
      tick(); tick();
      Reset = 1'b1;
      tick();

      // memory write, one wait state
      req(1'b1, 16'h1234, 16'hBEEF);
      chk("wr1_WE", WE, 0); chk("wr1_CE", CE, 0); chk("wr1_UB", UB, 0); chk("wr1_OE", OE, 1);
      chk("wr1_drive", sram_drive, 1); chk("wr1_ready", cpu_ready, 0);
      chk("wr1_ADDR", ADDR, 20'h01234); chk("wr1_d2s", Data_to_SRAM, 16'hBEEF);
      tick();
      chk("wr2_WE", WE, 0); chk("wr2_drive", sram_drive, 1); chk("wr2_ready", cpu_ready, 0);
      tick();
      chk("wr3_ready", cpu_ready, 1); chk("wr3_WE", WE, 1); chk("wr3_CE", CE, 1);
      chk("wr3_drive", sram_drive, 1);
      tick();
      chk("wr4_ready", cpu_ready, 0); chk("wr4_drive", sram_drive, 0);

      // memory read
      Data_from_SRAM = 16'h5A5A;
      req(1'b0, 16'h0042, 16'h0000);
      chk("rd1_OE", OE, 0); chk("rd1_CE", CE, 0); chk("rd1_WE", WE, 1);
      chk("rd1_drive", sram_drive, 0); chk("rd1_ADDR", ADDR, 20'h00042);
      tick();
      chk("rd2_OE", OE, 0); chk("rd2_ready", cpu_ready, 0);
      tick();
      chk("rd3_ready", cpu_ready, 1); chk("rd3_rdata", cpu_rdata, 16'h5A5A); chk("rd3_OE", OE, 1);
      tick();
      Data_from_SRAM = 16'h0000;
      chk("rd4_ready", cpu_ready, 0); chk("rd4_hold", cpu_rdata, 16'h5A5A);

      // transaction counter after one write and one read
      req(1'b0, 16'hFFFD, 16'h0000);
      chk("txn_ready", cpu_ready, 1); chk("txn_rdata", cpu_rdata, 16'h0002); chk("txn_CE", CE, 1);
      tick();

      // hex register write
      req(1'b1, 16'hFFFF, 16'h1234);
      chk("hex_ready", cpu_ready, 1); chk("hex_CE", CE, 1); chk("hex_early", hex_out, 16'h0000);
      tick();
      chk("hex_val", hex_out, 16'h1234); chk("hex_ready_off", cpu_ready, 0);
      chk("hex_rdata_kept", cpu_rdata, 16'h0002);

      // synchronized switches
      Switches = 16'hA5C3;
      tick(); tick();
      req(1'b0, 16'hFFFF, 16'h0000);
      chk("sw_rdata", cpu_rdata, 16'hA5C3); chk("sw_ready", cpu_ready, 1);
      tick();

      // LED register, unmapped read, ignored counter write
      req(1'b1, 16'hFFFE, 16'hFFFF);
      tick();
      chk("led_val", led_out, 12'hFFF);
      req(1'b0, 16'hFFFE, 16'h0000);
      chk("led_rb", cpu_rdata, 16'h0FFF);
      tick();
      req(1'b0, 16'hFFF5, 16'h0000);
      chk("unmapped_rd", cpu_rdata, 16'h0000);
      tick();
      req(1'b1, 16'hFFFD, 16'h1234);
      tick();
      req(1'b0, 16'hFFFD, 16'h0000);
      chk("txn_after_io", cpu_rdata, 16'h0002);
      chk("hex_unchanged", hex_out, 16'h1234); chk("led_unchanged", led_out, 12'hFFF);
      tick();

      // reset in the middle of a memory write
      req(1'b1, 16'h0100, 16'h1111);
      chk("ab_WE_low", WE, 0);
      #2 Reset = 1'b0;
      #1;
      chk("ab_WE", WE, 1); chk("ab_CE", CE, 1); chk("ab_drive", sram_drive, 0);
      chk("ab_ready", cpu_ready, 0); chk("ab_hex", hex_out, 0); chk("ab_led", led_out, 0);
      chk("ab_rdata", cpu_rdata, 0); chk("ab_ADDR", ADDR, 0);
      tick();
      Reset = 1'b1;
      tick();
      chk("ab_no_ready", cpu_ready, 0); chk("ab_WE_idle", WE, 1);

      Data_from_SRAM = 16'h1357;
      req(1'b0, 16'h0042, 16'h0000);
      chk("post_OE", OE, 0);
      tick(); tick();
      chk("post_ready", cpu_ready, 1); chk("post_rdata", cpu_rdata, 16'h1357);
      tick();
      req(1'b0, 16'hFFFD, 16'h0000);
      chk("post_txn", cpu_rdata, 16'h0001);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem2io_ctrl.md
# mem2io_ctrl

Parametrised memory/I-O controller sitting between the SLC-3 datapath (MAR/MDR side) and the external asynchronous SRAM plus board I/O. It replaces the fixed-timing Mem2IO path with a request/ready handshake, a configurable number of SRAM wait states and a small memory-mapped register bank: switches, hex display, LEDs and a transaction counter. The tristate pad buffer stays outside this block and is driven from `sram_drive`.

## Interface
Parameters:
- DATA_W, 16, CPU/SRAM data width (multiple of 4)
- CPU_ADDR_W, 16, CPU address width
- ADDR_W, 20, SRAM address width (≥ CPU_ADDR_W)
- HEX_DIGITS, 4, hex nibbles exported (HEX_DIGITS*4 ≤ DATA_W)
- LED_W, 12, LED register width (≤ DATA_W)
- WAIT_STATES, 1, extra SRAM access cycles (≥ 0)
- IO_BASE, 16'hFFF0, first I/O address; addresses ≥ IO_BASE are I/O

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  start transaction (sampled only in IDLE)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  CPU_ADDR_W  transaction address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1 and held until next read completes
- cpu_ready  out  1  one-cycle completion pulse
- Switches  in  DATA_W  raw board switches (asynchronous)
- hex_out  out  HEX_DIGITS*4  hex display register
- led_out  out  LED_W  LED register
- CE, OE, WE  out  1 each  SRAM strobes, active-low
- UB, LB  out  1 each  byte lanes, active-low, tied to CE
- ADDR  out  ADDR_W  SRAM address, zero-extended latched cpu_addr
- Data_to_SRAM  out  DATA_W  latched write data
- Data_from_SRAM  in  DATA_W  SRAM read data
- sram_drive  out  1  tristate enable toward SRAM

## Operation
- FSM states: IDLE, MEM_ACC, MEM_END, IO_ACC.
- IDLE: strobes high, sram_drive=0. On cpu_req: latch addr/we/wdata, go IO_ACC if addr ≥ IO_BASE, else MEM_ACC with wait counter = WAIT_STATES.
- MEM_ACC: CE=UB=LB=0; read: OE=0; write: WE=0, sram_drive=1. Counter decrements each cycle; at 0 → MEM_END; on that edge (read) capture Data_from_SRAM into cpu_rdata.
- MEM_END: all strobes high; sram_drive stays 1 for writes (hold cycle); cpu_ready=1; txn counter +1 (wraps at 2^DATA_W); → IDLE.
- IO_ACC: no SRAM strobes; cpu_ready=1; → IDLE. Map:
  - 16'hFFFF: read = synchronized switches; write = hex_out ← wdata[HEX_DIGITS*4-1:0]
  - 16'hFFFE: read = zero-extended led_out; write = led_out ← wdata[LED_W-1:0]
  - 16'hFFFD: read = txn counter; write ignored
  - other I/O addresses: read 0, write ignored
- cpu_req while not IDLE is ignored; a held cpu_req restarts a new transaction from IDLE (one idle cycle between transactions).
- Switches pass through a 2-flop synchronizer before use.
- Reset (async, low): state IDLE, CE/OE/WE/UB/LB=1, sram_drive=0, cpu_ready=0, cpu_rdata=0, hex_out=0, led_out=0, txn counter=0, synchronizer flops=0, ADDR=0, Data_to_SRAM=0. Reset mid-transaction aborts it: strobes deassert immediately, no cpu_ready, registers unchanged except reset values.

## Timing
- Request sampled at edge k.
- Memory: MEM_ACC cycles k+1 … k+1+WAIT_STATES (WAIT_STATES+1 cycles); cpu_ready in cycle k+2+WAIT_STATES. WAIT_STATES=0 → one access cycle, ready at k+2.
- Write: WE low WAIT_STATES+1 cycles; sram_drive high WAIT_STATES+2 cycles (covers hold).
- I/O: cpu_ready and cpu_rdata valid in cycle k+1; I/O register writes visible from cycle k+2.
- Switch change visible to I/O reads 2 cycles after settling.
- Counter increments on the edge leaving MEM_END; I/O transactions do not count.

## Test plan
- Reset: drive Reset=0 mid-cycle -> all strobes 1, sram_drive 0, hex_out/led_out/cpu_rdata 0 immediately, without a clock edge.
- Memory write, WAIT_STATES=1, addr 16'h1234, data 16'hBEEF -> ADDR=20'h01234, WE low 2 cycles, sram_drive high 3 cycles, cpu_ready one cycle at k+3.
- Memory read 16'h0042, Data_from_SRAM=16'h5A5A -> OE low 2 cycles, cpu_rdata=16'h5A5A with ready at k+3; read 16'hFFFD then returns 16'h0002 (write + read counted).
- I/O: write 16'hFFFF ← 16'h1234 -> hex_out=16'h1234, CE never low, ready at k+1; Switches=16'hA5C3 stable 2 cycles, read 16'hFFFF -> 16'hA5C3.
- LED: write 16'hFFFE ← 16'hFFFF (LED_W=12) -> led_out=12'hFFF, readback 16'h0FFF; read 16'hFFF5 -> 16'h0000; write 16'hFFFD ignored.
- Reset pulse during MEM_ACC of a write -> no cpu_ready, WE high immediately; after release, a new read completes normally with counter at 1.
